ex_mem_reg: RTL

EX_MEM_REG -- requirements
Module: EX_MEM_reg

---
 rtl/ex_mem_reg.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with a data-SRAM request FSM that tracks responses
// orphaned by flushes so their data_ok pulses can be filtered out downstream.
module ex_mem_reg (
  input  logic         clk,
  input  logic         reset,
  input  logic         empty,
  input  logic         in_valid,
  output logic         in_allowin,
  input  logic [165:0] in_data,
  input  logic         out_allowin,
  output logic         out_valid,
  output logic [165:0] out_data,
  output logic         valid,
  input  logic         in_mem_en,
  input  logic         in_mem_we,
  input  logic [1:0]   in_mem_size,
  input  logic [31:0]  in_mem_addr,
  input  logic [31:0]  in_mem_wdata,
  input  logic [3:0]   in_mem_wstrb,
  output logic         data_sram_req,
  output logic         data_sram_wr,
  output logic [1:0]   data_sram_size,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic [3:0]   data_sram_wstrb,
  input  logic         data_sram_addr_ok,
  input  logic         data_sram_data_ok,
  output logic         mem_req_is_use,
  output logic         data_ok_filtered
);

  localparam int unsigned DATA_W = 166;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DROP_W = 2;
  localparam logic [DROP_W-1:0] DROP_MAX = DROP_W'(3);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_DONE   = 2'd2,
    S_CANCEL = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_valid;
  logic [DROP_W-1:0]   r_drop_cnt;
  logic                w_drop_inc;
  logic                w_drop_dec;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [1:0]          r_mem_size;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic [3:0]          r_mem_wstrb;
  logic                w_ready_go;
  logic                w_out_valid;
  logic                w_in_allowin;
  logic                w_capture;
  logic                w_out_fire;

  // Handshake: a memory op may only leave once its address has been accepted
  assign w_ready_go   = !r_mem_en || (r_state == S_DONE);
  assign w_out_valid  = r_valid && w_ready_go;
  assign w_in_allowin = (!r_valid || (w_ready_go && out_allowin)) &&
                        (r_state != S_CANCEL) && (r_drop_cnt != DROP_MAX);
  assign w_capture    = w_in_allowin && in_valid && !empty;
  assign w_out_fire   = w_out_valid && out_allowin;

  // Next-state and orphaned-response bookkeeping
  always_comb begin
    w_state_nxt = r_state;
    w_drop_inc  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_capture && in_mem_en) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (data_sram_addr_ok) begin
          if (empty) begin
            w_state_nxt = S_IDLE;
            w_drop_inc  = 1'b1;
          end else begin
            w_state_nxt = S_DONE;
          end
        end else if (empty) begin
          w_state_nxt = S_CANCEL;
        end
      end
      S_DONE: begin
        if (w_capture) begin
          w_state_nxt = in_mem_en ? S_REQ : S_IDLE;
        end else if (empty) begin
          w_state_nxt = S_IDLE;
          w_drop_inc  = 1'b1;
        end else if (w_out_fire) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CANCEL: begin
        if (data_sram_addr_ok) begin
          w_state_nxt = S_IDLE;
          w_drop_inc  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A data_ok coinciding with a new drop cancels it out, even at zero
  assign w_drop_dec = data_sram_data_ok && ((r_drop_cnt != '0) || w_drop_inc);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_drop_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_drop_inc && !w_drop_dec && (r_drop_cnt != DROP_MAX))
        r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      else if (w_drop_dec && !w_drop_inc)
        r_drop_cnt <= r_drop_cnt - DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else if (empty) begin
      r_valid <= 1'b0;
    end else if (w_in_allowin) begin
      r_valid <= in_valid;
    end
  end

  // Holding registers also source the SRAM bus, keeping it stable until addr_ok
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data      <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_size  <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wstrb <= '0;
    end else if (w_capture) begin
      r_data      <= in_data;
      r_mem_en    <= in_mem_en;
      r_mem_we    <= in_mem_we;
      r_mem_size  <= in_mem_size;
      r_mem_addr  <= in_mem_addr;
      r_mem_wdata <= in_mem_wdata;
      r_mem_wstrb <= in_mem_wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data <= '0;
    end else if (empty) begin
      r_out_data <= '0;
    end else if (w_out_fire) begin
      r_out_data <= r_data;
    end
  end

  assign in_allowin       = w_in_allowin;
  assign out_valid        = w_out_valid;
  assign out_data         = r_out_data;
  assign valid            = r_valid;
  assign data_sram_req    = (r_state == S_REQ) || (r_state == S_CANCEL);
  assign data_sram_wr     = r_mem_we;
  assign data_sram_size   = r_mem_size;
  assign data_sram_addr   = r_mem_addr;
  assign data_sram_wdata  = r_mem_wdata;
  assign data_sram_wstrb  = r_mem_wstrb;
  assign mem_req_is_use   = r_valid && r_mem_en;
  assign data_ok_filtered = data_sram_data_ok && (r_drop_cnt == '0);

endmodule
